branch_target_ctrl: RTL and testbench

Multi-cycle branch resolution controller for the 64-bit CPU datapath. It accepts one conditional or unconditional branch request and internally forms the doubled immediate (imm << 1). It computes the target and evaluates the branch condition, then drives the next PC and the redirect/stall signals for the PC register. It sits between decode/register-read and the PC mux, and replaces ad-hoc edge tricks with an explicit, fully rising-edge sequencer.

---
 rtl/branch_target_ctrl.sv | 179 +++++++++++++++++
 tb/tb_branch_target_ctrl.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/branch_target_ctrl.sv
// ============================================================================
// Module   : branch_target_ctrl
// Brief    : Three-state branch resolution sequencer: latch, compute target
//            and condition, then publish next PC with redirect/stall control.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module branch_target_ctrl #(
    parameter int XLEN  = 64,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             br_req,
    output logic             br_ready,
    input  logic [XLEN-1:0]  br_pc,
    input  logic [XLEN-1:0]  br_imm,
    input  logic [2:0]       br_funct3,
    input  logic             br_uncond,
    input  logic [XLEN-1:0]  br_rs1,
    input  logic [XLEN-1:0]  br_rs2,
    output logic             stall,
    output logic             done,
    output logic             taken,
    output logic             redirect,
    output logic [XLEN-1:0]  next_pc,
    output logic             illegal,
    output logic [CNT_W-1:0] taken_count
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CALC    = 2'd1,
        S_RESOLVE = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_next_state;

    logic [XLEN-1:0]   r_pc;
    logic [XLEN-1:0]   r_imm;
    logic [2:0]        r_funct3;
    logic              r_uncond;
    logic [XLEN-1:0]   r_rs1;
    logic [XLEN-1:0]   r_rs2;
    logic [XLEN-1:0]   r_s_imm;
    logic              r_cond;
    logic              r_bad_funct3;

    logic              r_stall;
    logic              r_done;
    logic              r_taken;
    logic              r_redirect;
    logic [XLEN-1:0]   r_next_pc;
    logic              r_illegal;
    logic [CNT_W-1:0]  r_taken_count;

    logic              w_cond;
    logic              w_bad_funct3;
    logic              w_taken;
    logic              w_illegal;
    logic [XLEN-1:0]   w_target;
    logic [XLEN-1:0]   w_fall;

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:    if (br_req) w_next_state = S_CALC;
            S_CALC:    w_next_state = S_RESOLVE;
            S_RESOLVE: w_next_state = S_IDLE;
            default:   w_next_state = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Condition evaluation on the latched operands
    // ------------------------------------------------------------------
    always_comb begin
        w_cond       = 1'b0;
        w_bad_funct3 = 1'b0;
        case (r_funct3)
            3'b000:  w_cond = (r_rs1 == r_rs2);
            3'b001:  w_cond = (r_rs1 != r_rs2);
            3'b100:  w_cond = ($signed(r_rs1) <  $signed(r_rs2));
            3'b101:  w_cond = ($signed(r_rs1) >= $signed(r_rs2));
            3'b110:  w_cond = (r_rs1 <  r_rs2);
            3'b111:  w_cond = (r_rs1 >= r_rs2);
            default: w_bad_funct3 = 1'b1;
        endcase
    end

    // Unconditional jumps override both the condition and the funct3 check.
    assign w_taken   = r_uncond | r_cond;
    assign w_illegal = ~r_uncond & r_bad_funct3;
    assign w_target  = r_pc + r_s_imm;
    assign w_fall    = r_pc + XLEN'(4);

    // ------------------------------------------------------------------
    // Operand latch, pipeline registers and outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc          <= '0;
            r_imm         <= '0;
            r_funct3      <= '0;
            r_uncond      <= 1'b0;
            r_rs1         <= '0;
            r_rs2         <= '0;
            r_s_imm       <= '0;
            r_cond        <= 1'b0;
            r_bad_funct3  <= 1'b0;
            r_stall       <= 1'b0;
            r_done        <= 1'b0;
            r_taken       <= 1'b0;
            r_redirect    <= 1'b0;
            r_next_pc     <= '0;
            r_illegal     <= 1'b0;
            r_taken_count <= '0;
        end else begin
            r_stall    <= (w_next_state != S_IDLE);
            r_done     <= 1'b0;
            r_redirect <= 1'b0;
            r_illegal  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (br_req) begin
                        r_pc     <= br_pc;
                        r_imm    <= br_imm;
                        r_funct3 <= br_funct3;
                        r_uncond <= br_uncond;
                        r_rs1    <= br_rs1;
                        r_rs2    <= br_rs2;
                    end
                end
                S_CALC: begin
                    // Top bit of the immediate falls off the doubled offset.
                    r_s_imm      <= {r_imm[XLEN-2:0], 1'b0};
                    r_cond       <= w_cond;
                    r_bad_funct3 <= w_bad_funct3;
                end
                S_RESOLVE: begin
                    r_done     <= 1'b1;
                    r_taken    <= w_taken;
                    r_redirect <= w_taken;
                    r_illegal  <= w_illegal;
                    r_next_pc  <= w_taken ? w_target : w_fall;
                    if (w_taken && (r_taken_count != {CNT_W{1'b1}})) begin
                        r_taken_count <= r_taken_count + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign br_ready    = (r_state == S_IDLE);
    assign stall       = r_stall;
    assign done        = r_done;
    assign taken       = r_taken;
    assign redirect    = r_redirect;
    assign next_pc     = r_next_pc;
    assign illegal     = r_illegal;
    assign taken_count = r_taken_count;

endmodule

`default_nettype wire

// File: tb/tb_branch_target_ctrl.sv
// ============================================================================
// Module   : tb_branch_target_ctrl
// Brief    : Scoreboard bench for branch_target_ctrl with directed vectors.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_branch_target_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        br_req;
    logic        br_ready;
    logic [63:0] br_pc;
    logic [63:0] br_imm;
    logic [2:0]  br_funct3;
    logic        br_uncond;
    logic [63:0] br_rs1;
    logic [63:0] br_rs2;
    logic        stall;
    logic        done;
    logic        taken;
    logic        redirect;
    logic [63:0] next_pc;
    logic        illegal;
    logic [31:0] taken_count;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    branch_target_ctrl #(.XLEN(64), .CNT_W(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .br_req     (br_req),
        .br_ready   (br_ready),
        .br_pc      (br_pc),
        .br_imm     (br_imm),
        .br_funct3  (br_funct3),
        .br_uncond  (br_uncond),
        .br_rs1     (br_rs1),
        .br_rs2     (br_rs2),
        .stall      (stall),
        .done       (done),
        .taken      (taken),
        .redirect   (redirect),
        .next_pc    (next_pc),
        .illegal    (illegal),
        .taken_count(taken_count)
    );

    typedef struct {
        int          cyc;
        logic        tk;
        logic [63:0] npc;
        logic        il;
        logic [31:0] cnt;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    logic [31:0] exp_cnt = '0;
    int          checks = 0;
    int          failures = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (reset === 1'b0) begin
            if (done) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", done, 1'b0);
                end else begin
                    e = sb.pop_front();
                    chk("done_cycle",  cyc,         e.cyc);
                    chk("taken",       taken,       e.tk);
                    chk("redirect",    redirect,    e.tk);
                    chk("next_pc",     next_pc,     e.npc);
                    chk("illegal",     illegal,     e.il);
                    chk("taken_count", taken_count, e.cnt);
                end
            end else begin
                chk("redirect_idle", redirect, 1'b0);
                chk("illegal_idle",  illegal,  1'b0);
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (!br_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("ready_timeout", br_ready, 1'b1);
    endtask

    task automatic send(input logic [63:0] pc, input logic [63:0] imm, input logic [2:0] f3,
                        input logic unc, input logic [63:0] rs1, input logic [63:0] rs2,
                        input logic tk, input logic [63:0] npc, input logic il);
        int a;
        wait_ready();
        br_pc = pc; br_imm = imm; br_funct3 = f3; br_uncond = unc;
        br_rs1 = rs1; br_rs2 = rs2; br_req = 1'b1;
        @(posedge clk); #1;
        a = cyc;
        // Scramble the inputs while in flight; the latched request must win.
        br_req = 1'b0; br_rs1 = ~rs1; br_rs2 = rs2 ^ 64'h55; br_funct3 = ~f3;
        br_pc = ~pc; br_imm = ~imm; br_uncond = ~unc;
        if (tk && exp_cnt != '1) exp_cnt++;
        sb.push_back('{a + 2, tk, npc, il, exp_cnt});
        chk("stall_c1", stall, 1'b1);
        chk("ready_busy", br_ready, 1'b0);
        @(posedge clk); #1;
        chk("stall_c2", stall, 1'b1);
        @(posedge clk); #1;
        chk("stall_done", stall, 1'b0);
        chk("ready_done", br_ready, 1'b1);
    endtask

    initial begin
        int a;
        reset = 1'b1; br_req = 1'b0; br_pc = '0; br_imm = '0; br_funct3 = '0;
        br_uncond = 1'b0; br_rs1 = '0; br_rs2 = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        chk("rst_ready", br_ready, 1'b1);
        chk("rst_stall", stall, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_taken", taken, 1'b0);
        chk("rst_next_pc", next_pc, 64'h0);
        chk("rst_count", taken_count, 32'h0);

        //   pc                     imm                    f3      unc   rs1                    rs2    tk    next_pc                ill
        send(64'h100,               64'h10,                3'b000, 1'b0, 64'd5,                 64'd5, 1'b1, 64'h120,               1'b0);
        send(64'h100,               64'h10,                3'b001, 1'b0, 64'd5,                 64'd5, 1'b0, 64'h104,               1'b0);
        send(64'h100,               64'h10,                3'b100, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b1, 64'h120,             1'b0);
        send(64'h100,               64'h10,                3'b110, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'h104,             1'b0);
        send(64'h100,               64'h10,                3'b101, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'h104,             1'b0);
        send(64'h100,               64'h10,                3'b111, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b1, 64'h120,             1'b0);
        send(64'h200,               64'hFFFF_FFFF_FFFF_FFF8, 3'b000, 1'b0, 64'd5,               64'd5, 1'b1, 64'h1F0,               1'b0);
        send(64'hFFFF_FFFF_FFFF_FFFC, 64'h2,               3'b000, 1'b0, 64'd0,                 64'd0, 1'b1, 64'h0,                 1'b0);
        send(64'h100,               64'h8000_0000_0000_0001, 3'b000, 1'b0, 64'd5,               64'd5, 1'b1, 64'h102,               1'b0);
        send(64'h400,               64'h10,                3'b010, 1'b0, 64'd5,                 64'd5, 1'b0, 64'h404,               1'b1);
        send(64'h400,               64'h10,                3'b010, 1'b1, 64'd5,                 64'd5, 1'b1, 64'h420,               1'b0);
        send(64'h400,               64'h10,                3'b011, 1'b0, 64'd3,                 64'd9, 1'b0, 64'h404,               1'b1);

        // br_req held across five edges: accepted at a and a+3 only.
        wait_ready();
        br_pc = 64'h300; br_imm = 64'h4; br_funct3 = 3'b000; br_uncond = 1'b0;
        br_rs1 = 64'd7; br_rs2 = 64'd7; br_req = 1'b1;
        @(posedge clk); #1;
        a = cyc;
        exp_cnt++;
        sb.push_back('{a + 2, 1'b1, 64'h308, 1'b0, exp_cnt});
        repeat (3) @(posedge clk);
        #1;
        exp_cnt++;
        sb.push_back('{a + 5, 1'b1, 64'h308, 1'b0, exp_cnt});
        @(posedge clk); #1;
        br_req = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("hs_drained", sb.size(), 0);

        // Reset while in RESOLVE: the in-flight request must vanish.
        wait_ready();
        br_pc = 64'h500; br_imm = 64'h8; br_funct3 = 3'b000; br_uncond = 1'b1;
        br_rs1 = 64'd1; br_rs2 = 64'd1; br_req = 1'b1;
        @(posedge clk); #1;
        br_req = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        exp_cnt = '0;
        chk("abort_done", done, 1'b0);
        chk("abort_ready", br_ready, 1'b1);
        chk("abort_stall", stall, 1'b0);
        chk("abort_count", taken_count, 32'h0);
        chk("abort_next_pc", next_pc, 64'h0);
        repeat (3) @(posedge clk);
        #1;

        send(64'h100, 64'h10, 3'b000, 1'b0, 64'd5, 64'd5, 1'b1, 64'h120, 1'b0);

        repeat (5) @(posedge clk);
        #1;
        chk("sb_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
